// File: rtl/srio_tx_pkt_fifo.sv
// srio_tx_pkt_fifo
// Store-and-forward packet buffer between the DMA split stage and the SRIO
// core transmit AXIS port. A packet becomes visible to the read side only
// once its TLAST beat is stored. It then leaves as one unbroken run of
// beats with TVALID held high. Packets longer than MAX_PKT_BEATS are
// discarded, and their space is reclaimed.
//
// Ports
//   AXIS_ACLK, AXIS_ARESET   : clock, synchronous active-high reset
//   S_AXIS_*                 : 64-bit input stream, TUSER sampled on beat 0
//   M_AXIS_*                 : 64-bit output stream, TUSER held per packet
//   pkt_count                : committed packets not yet fully sent
//   level                    : occupied beats, committed or not
//   drop_cnt, drop_pulse     : saturating drop counter and per-drop pulse
module srio_tx_pkt_fifo #(
  parameter int DEPTH_LOG2    = 9,
  parameter int MAX_PKT_BEATS = 33
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESET,
  input  logic [63:0]         S_AXIS_TDATA,
  input  logic                S_AXIS_TLAST,
  input  logic [31:0]         S_AXIS_TUSER,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  output logic [63:0]         M_AXIS_TDATA,
  output logic                M_AXIS_TLAST,
  output logic [31:0]         M_AXIS_TUSER,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  output logic [DEPTH_LOG2:0] pkt_count,
  output logic [DEPTH_LOG2:0] level,
  output logic [15:0]         drop_cnt,
  output logic                drop_pulse
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(MAX_PKT_BEATS + 1) + 1;
  localparam int MW    = 64 + 1 + 32;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT_BEATS);

  typedef enum logic {FILL, DROP} wr_state_t;
  typedef enum logic {IDLE, SEND} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [PW-1:0] wr_ptr, commit_ptr, fetch_ptr, rd_ptr;
  logic [CW-1:0] beat_cnt;
  logic [31:0]   user_hold;
  logic          rst_done;

  logic [MW-1:0] mem [0:DEPTH-1];
  logic [MW-1:0] pf_word;
  logic          pf_valid;

  logic          out_valid, out_last;
  logic [63:0]   out_data;
  logic [31:0]   out_user;
  logic [PW-1:0] pkt_cnt_q, pkt_count_nxt;
  logic [15:0]   drop_cnt_q;
  logic          drop_pulse_q;

  logic        s_fire, overflow, wr_en, commit;
  logic        m_fire, m_last_fire, avail, out_load, fetch_en;
  logic [31:0] wr_user;

  // level covers uncommitted beats and the beats still in the prefetch and
  // output registers, so rd_ptr advances only on downstream acceptance.
  assign level = wr_ptr - rd_ptr;

  // rst_done keeps TREADY low during reset and for the cycle in which reset
  // is released. While dropping, beats are discarded, so a full buffer must
  // not stall the drop.
  assign S_AXIS_TREADY = rst_done && (!level[DEPTH_LOG2] || (wr_state == DROP));

  assign s_fire      = S_AXIS_TVALID && S_AXIS_TREADY;
  // Beat MAX_PKT_BEATS+1 of a packet triggers the drop. That beat is never
  // stored.
  assign overflow    = s_fire && (wr_state == FILL) && (beat_cnt == MAX_CNT);
  assign wr_en       = s_fire && (wr_state == FILL) && !overflow;
  assign commit      = wr_en && S_AXIS_TLAST;
  assign wr_user     = (beat_cnt == '0) ? S_AXIS_TUSER : user_hold;

  assign m_fire      = out_valid && M_AXIS_TREADY;
  assign m_last_fire = m_fire && out_last;
  assign avail       = (commit_ptr != fetch_ptr);
  assign out_load    = !out_valid || M_AXIS_TREADY;
  // Fetch only committed beats. Refill the prefetch register whenever it is
  // empty or is draining into the output register on this edge. This keeps
  // one beat per cycle flowing with no bubble.
  assign fetch_en    = avail && ((rd_state == SEND) || (pkt_cnt_q != '0)) &&
                       (!pf_valid || out_load);

  always_comb begin
    pkt_count_nxt = pkt_cnt_q;
    if (commit && !m_last_fire)
      pkt_count_nxt = pkt_cnt_q + PW'(1);
    else if (!commit && m_last_fire)
      pkt_count_nxt = pkt_cnt_q - PW'(1);
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      FILL: if (overflow && !S_AXIS_TLAST) wr_state_nxt = DROP;
      DROP: if (s_fire && S_AXIS_TLAST) wr_state_nxt = FILL;
      default: wr_state_nxt = FILL;
    endcase
  end

  // If this packet's last beat is accepted while the next packet is already
  // committed, the read side stays in SEND so the next packet follows back
  // to back.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      IDLE: if (pkt_cnt_q != '0) rd_state_nxt = SEND;
      SEND: if (m_last_fire && (pkt_count_nxt == '0)) rd_state_nxt = IDLE;
      default: rd_state_nxt = IDLE;
    endcase
  end

  // Write side: pointers, per-packet beat count, commit and drop handling.
  // A drop rewinds wr_ptr to the last commit point, which frees the space.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      wr_state     <= FILL;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      beat_cnt     <= '0;
      user_hold    <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      rst_done     <= 1'b0;
    end else begin
      rst_done     <= 1'b1;
      wr_state     <= wr_state_nxt;
      drop_pulse_q <= overflow;
      if (overflow) begin
        wr_ptr   <= commit_ptr;
        beat_cnt <= '0;
        if (drop_cnt_q != 16'hFFFF)
          drop_cnt_q <= drop_cnt_q + 16'd1;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (beat_cnt == '0)
          user_hold <= S_AXIS_TUSER;
        if (S_AXIS_TLAST) begin
          commit_ptr <= wr_ptr + PW'(1);
          beat_cnt   <= '0;
        end else begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

  // Every beat stores the packet's TUSER alongside it, so the output can
  // hold TUSER without a separate per-packet sideband queue.
  always_ff @(posedge AXIS_ACLK) begin
    if (wr_en && !AXIS_ARESET)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {wr_user, S_AXIS_TLAST, S_AXIS_TDATA};
  end

  // Synchronous RAM read into the prefetch register. Fetch never targets
  // the write address, because fetch_ptr stays below commit_ptr.
  always_ff @(posedge AXIS_ACLK) begin
    if (fetch_en)
      pf_word <= mem[fetch_ptr[DEPTH_LOG2-1:0]];
  end

  // Read side: read FSM, prefetch/output pipeline and packet count.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      rd_state  <= IDLE;
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      pf_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      rd_state  <= rd_state_nxt;
      pkt_cnt_q <= pkt_count_nxt;
      pf_valid  <= fetch_en || (pf_valid && !out_load);
      if (fetch_en)
        fetch_ptr <= fetch_ptr + PW'(1);
      if (m_fire)
        rd_ptr <= rd_ptr + PW'(1);
      if (out_load) begin
        out_valid <= pf_valid;
        if (pf_valid)
          {out_user, out_last, out_data} <= pf_word;
      end
    end
  end

  assign M_AXIS_TDATA  = out_data;
  assign M_AXIS_TLAST  = out_last;
  assign M_AXIS_TUSER  = out_user;
  assign M_AXIS_TVALID = out_valid;
  assign pkt_count     = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign drop_pulse    = drop_pulse_q;

endmodule

// File: tb/tb_srio_tx_pkt_fifo.sv
// tb_srio_tx_pkt_fifo
// Scoreboard bench for srio_tx_pkt_fifo.
// - Each legal beat is pushed to exp_q when it is driven.
// - A negedge monitor captures accepted output beats into rx_q.
// - Each scenario task compares the two queues inline.
// The instance uses a 64-beat buffer, so that two 33-beat packets can
// fill it.
module tb_srio_tx_pkt_fifo;

  localparam int DL   = 6;
  localparam int MAXB = 33;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [31:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic [31:0]   s_user = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [63:0]   m_data;
  logic          m_last;
  logic [31:0]   m_user;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DL:0]   pkt_count;
  logic [DL:0]   level;
  logic [15:0]   drop_cnt;
  logic          drop_pulse;

  beat_t exp_q[$];
  beat_t rx_q[$];
  int    rx_cyc_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    gap_errs = 0;
  int    drop_pulses = 0;
  int    drop_cyc = 0;
  int    valid_rise_cyc = 0;
  logic  in_pkt = 1'b0;
  logic  prev_valid = 1'b0;
  int    beat_acc[64];
  int    beat_lvl[64];
  int    last_acc_cyc = 0;
  bit    fork_done;

  srio_tx_pkt_fifo #(.DEPTH_LOG2(DL), .MAX_PKT_BEATS(MAXB)) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESET  (rst),
    .S_AXIS_TDATA (s_data),
    .S_AXIS_TLAST (s_last),
    .S_AXIS_TUSER (s_user),
    .S_AXIS_TVALID(s_valid),
    .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA (m_data),
    .M_AXIS_TLAST (m_last),
    .M_AXIS_TUSER (m_user),
    .M_AXIS_TVALID(m_valid),
    .M_AXIS_TREADY(m_ready),
    .pkt_count    (pkt_count),
    .level        (level),
    .drop_cnt     (drop_cnt),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The output monitor captures beats and flags TVALID gaps inside a packet.
  always @(negedge clk) begin
    if (rst) begin
      in_pkt     <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (m_valid && !prev_valid) valid_rise_cyc <= cyc;
      if (in_pkt && !m_valid) gap_errs <= gap_errs + 1;
      if (m_valid && m_ready) begin
        rx_q.push_back('{data: m_data, last: m_last, user: m_user});
        rx_cyc_q.push_back(cyc);
        in_pkt <= !m_last;
      end
      if (drop_pulse) begin
        drop_pulses <= drop_pulses + 1;
        drop_cyc    <= cyc;
      end
      prev_valid <= m_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, input logic [31:0] u,
                           output int acc, output int lvl);
    bit done = 0;
    s_data  = d;
    s_last  = l;
    s_user  = u;
    s_valid = 1'b1;
    acc = -1;
    lvl = -1;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        tick();
        acc  = cyc;
        lvl  = int'(level);
        done = 1;
      end
    end
    s_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: beat %h not accepted, TREADY=%b, required 1", d, s_ready);
    end
  endtask

  task automatic send_pkt(input int n, input logic [63:0] base, input logic [31:0] user,
                          input bit gaps, input bit legal);
    int acc, lvl;
    for (int i = 0; i < n; i++) begin
      if (legal)
        exp_q.push_back('{data: base + 64'(i), last: (i == n - 1), user: user});
      send_beat(base + 64'(i), (i == n - 1), (i == 0) ? user : 32'h0, acc, lvl);
      beat_acc[i] = acc;
      beat_lvl[i] = lvl;
      last_acc_cyc = acc;
      if (gaps && i < n - 1) tick();
    end
  endtask

  task automatic wait_rx();
    for (int t = 0; t < 3000 && rx_q.size() < exp_q.size(); t++) tick();
    vectors++;
    if (rx_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL rx_count: got %0d beats, required %0d", rx_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_tready: got %b, required 0", s_ready); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_tvalid: got %b, required 0", m_valid); end
    vectors++; if ({m_data, m_last, m_user} !== 97'd0) begin miscompares++; $display("[TB] FAIL rst_mout: got %h/%b/%h, required 0", m_data, m_last, m_user); end
    vectors++; if (pkt_count !== 0 || level !== 0) begin miscompares++; $display("[TB] FAIL rst_counts: got pkt=%0d level=%0d, required 0/0", pkt_count, level); end
    vectors++; if (drop_cnt !== 0 || drop_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_drop: got cnt=%0d pulse=%b, required 0/0", drop_cnt, drop_pulse); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rel_tready0: got %b, required 0", s_ready); end
    @(negedge clk);
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rel_tready1: got %b, required 1", s_ready); end
    tick();
  endtask

  task automatic test_single_packet();
    int g0 = gap_errs;
    beat_t e, r;
    m_ready = 1'b1;
    send_pkt(4, 64'h1, 32'hA5A50001, 0, 1);
    vectors++; if (pkt_count !== 1) begin miscompares++; $display("[TB] FAIL single_pkt_count: got %0d, required 1", pkt_count); end
    wait_rx();
    vectors++; if (valid_rise_cyc != last_acc_cyc + 2) begin miscompares++; $display("[TB] FAIL single_latency: got %0d, required %0d", valid_rise_cyc - last_acc_cyc, 2); end
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc_q.pop_front());
      vectors++;
      if (r !== e) begin miscompares++; $display("[TB] FAIL single_beat: got %h/%b/%h, required %h/%b/%h", r.data, r.last, r.user, e.data, e.last, e.user); end
    end
    tick();
    vectors++; if (pkt_count !== 0 || gap_errs != g0) begin miscompares++; $display("[TB] FAIL single_end: got pkt=%0d gaps=%0d, required 0/0", pkt_count, gap_errs - g0); end
  endtask

  task automatic test_gapped_input();
    int g0 = gap_errs;
    int first_cyc = -1, prev_cyc = -1, span_err = 0;
    beat_t e, r;
    m_ready = 1'b1;
    send_pkt(8, 64'h10, 32'h12340002, 1, 1);
    wait_rx();
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      prev_cyc = rx_cyc_q.pop_front();
      if (first_cyc < 0) first_cyc = prev_cyc;
      vectors++;
      if (r !== e) begin miscompares++; $display("[TB] FAIL gapped_beat: got %h/%b/%h, required %h/%b/%h", r.data, r.last, r.user, e.data, e.last, e.user); end
    end
    span_err = (prev_cyc - first_cyc != 7);
    vectors++; if (first_cyc != last_acc_cyc + 2) begin miscompares++; $display("[TB] FAIL gapped_first: got cycle %0d, required %0d", first_cyc, last_acc_cyc + 2); end
    vectors++; if (span_err || gap_errs != g0) begin miscompares++; $display("[TB] FAIL gapped_contig: got span %0d gaps %0d, required 7/0", prev_cyc - first_cyc, gap_errs - g0); end
  endtask

  task automatic test_full();
    int g0 = gap_errs;
    int first_cyc = -1, prev_cyc = -1;
    beat_t e, r;
    m_ready = 1'b0;
    fork_done = 0;
    send_pkt(MAXB, 64'h1000, 32'hF0000001, 0, 1);
    fork
      begin
        send_pkt(MAXB, 64'h2000, 32'hF0000002, 0, 1);
        fork_done = 1;
      end
    join_none
    for (int t = 0; t < 200 && level !== 64; t++) tick();
    @(negedge clk);
    vectors++; if (level !== 64) begin miscompares++; $display("[TB] FAIL full_level: got %0d, required 64", level); end
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_tready: got %b, required 0", s_ready); end
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (s_ready !== 1'b1 || level !== 63) begin miscompares++; $display("[TB] FAIL full_release: got tready=%b level=%0d, required 1/63", s_ready, level); end
    for (int t = 0; t < 500 && !fork_done; t++) tick();
    wait_rx();
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      prev_cyc = rx_cyc_q.pop_front();
      if (first_cyc < 0) first_cyc = prev_cyc;
      vectors++;
      if (r !== e) begin miscompares++; $display("[TB] FAIL full_beat: got %h/%b/%h, required %h/%b/%h", r.data, r.last, r.user, e.data, e.last, e.user); end
    end
    vectors++; if (prev_cyc - first_cyc != 2 * MAXB - 1 || gap_errs != g0) begin miscompares++; $display("[TB] FAIL full_b2b: got span %0d gaps %0d, required %0d/0", prev_cyc - first_cyc, gap_errs - g0, 2 * MAXB - 1); end
    tick();
    vectors++; if (pkt_count !== 0 || drop_cnt !== 0) begin miscompares++; $display("[TB] FAIL full_end: got pkt=%0d drops=%0d, required 0/0", pkt_count, drop_cnt); end
  endtask

  task automatic test_drop();
    int p0 = drop_pulses;
    beat_t e, r;
    m_ready = 1'b1;
    send_pkt(MAXB + 2, 64'h3000, 32'hDEAD0003, 0, 0);
    vectors++; if (beat_lvl[MAXB - 1] != MAXB) begin miscompares++; $display("[TB] FAIL drop_lvl_max: got %0d, required %0d", beat_lvl[MAXB - 1], MAXB); end
    vectors++; if (beat_lvl[MAXB] != 0) begin miscompares++; $display("[TB] FAIL drop_lvl_rewind: got %0d, required 0", beat_lvl[MAXB]); end
    tick();
    vectors++; if (drop_pulses != p0 + 1 || drop_cyc != beat_acc[MAXB]) begin miscompares++; $display("[TB] FAIL drop_pulse: got %0d pulses at %0d, required 1 at %0d", drop_pulses - p0, drop_cyc, beat_acc[MAXB]); end
    vectors++; if (drop_cnt !== 1 || level !== 0) begin miscompares++; $display("[TB] FAIL drop_cnt: got cnt=%0d level=%0d, required 1/0", drop_cnt, level); end
    send_pkt(2, 64'h4000, 32'hBEEF0004, 0, 1);
    wait_rx();
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc_q.pop_front());
      vectors++;
      if (r !== e) begin miscompares++; $display("[TB] FAIL drop_beat: got %h/%b/%h, required %h/%b/%h", r.data, r.last, r.user, e.data, e.last, e.user); end
    end
  endtask

  task automatic test_simultaneous();
    int acc, lvl;
    beat_t e, r;
    m_ready = 1'b0;
    send_pkt(1, 64'h5000, 32'hB0000005, 0, 1);
    repeat (3) tick();
    vectors++; if (pkt_count !== 1) begin miscompares++; $display("[TB] FAIL simul_pre: got %0d, required 1", pkt_count); end
    exp_q.push_back('{data: 64'h6000, last: 1'b0, user: 32'hB0000006});
    send_beat(64'h6000, 1'b0, 32'hB0000006, acc, lvl);
    exp_q.push_back('{data: 64'h6001, last: 1'b0, user: 32'hB0000006});
    send_beat(64'h6001, 1'b0, 32'h0, acc, lvl);
    exp_q.push_back('{data: 64'h6002, last: 1'b1, user: 32'hB0000006});
    s_data = 64'h6002; s_last = 1'b1; s_user = 32'h0; s_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    vectors++; if (s_ready !== 1'b1 || m_valid !== 1'b1 || m_last !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_setup: got tready=%b tvalid=%b tlast=%b, required 1/1/1", s_ready, m_valid, m_last); end
    tick();
    s_valid = 1'b0;
    vectors++; if (pkt_count !== 1 || level !== 3) begin miscompares++; $display("[TB] FAIL simul_counts: got pkt=%0d level=%0d, required 1/3", pkt_count, level); end
    wait_rx();
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc_q.pop_front());
      vectors++;
      if (r !== e) begin miscompares++; $display("[TB] FAIL simul_beat: got %h/%b/%h, required %h/%b/%h", r.data, r.last, r.user, e.data, e.last, e.user); end
    end
    tick();
    vectors++; if (pkt_count !== 0) begin miscompares++; $display("[TB] FAIL simul_end: got %0d, required 0", pkt_count); end
  endtask

  task automatic test_reset_mid();
    int acc, lvl;
    beat_t e, r;
    m_ready = 1'b0;
    send_pkt(3, 64'h7000, 32'hC0000007, 0, 0);
    exp_q.push_back('{data: 64'h7000, last: 1'b0, user: 32'hC0000007});
    repeat (3) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    send_beat(64'h8000, 1'b0, 32'hC0000008, acc, lvl);
    send_beat(64'h8001, 1'b0, 32'h0, acc, lvl);
    s_data = 64'h8002; s_last = 1'b0; s_valid = 1'b1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++; if (s_ready !== 1'b0 || m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_valid: got tready=%b tvalid=%b, required 0/0", s_ready, m_valid); end
    vectors++; if ({m_data, m_last, m_user} !== 97'd0) begin miscompares++; $display("[TB] FAIL mid_rst_mout: got %h/%b/%h, required 0", m_data, m_last, m_user); end
    vectors++; if (pkt_count !== 0 || level !== 0 || drop_cnt !== 0 || drop_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_counts: got pkt=%0d level=%0d drops=%0d pulse=%b, required 0/0/0/0", pkt_count, level, drop_cnt, drop_pulse); end
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    tick();
    send_pkt(3, 64'h9000, 32'hC0000009, 0, 1);
    wait_rx();
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc_q.pop_front());
      vectors++;
      if (r !== e) begin miscompares++; $display("[TB] FAIL mid_beat: got %h/%b/%h, required %h/%b/%h", r.data, r.last, r.user, e.data, e.last, e.user); end
    end
    repeat (4) tick();
    vectors++; if (rx_q.size() != 0 || pkt_count !== 0) begin miscompares++; $display("[TB] FAIL mid_extra: got %0d extra beats pkt=%0d, required 0/0", rx_q.size(), pkt_count); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_gapped_input();
    test_full();
    test_drop();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
